// File: rtl/capture_trigger_ctrl_if.sv
// Write-port bundle between the capture sequencer (master) and the raw IQ capture RAM (slave).
// Each word is {ch1, ch0}; ram_wren doubles as the RAM clock enable.
interface capture_trigger_ctrl_if #(
   parameter int ADDR_BITS = 10,
   parameter int DATA_BITS = 16
);
   logic [ADDR_BITS-1:0]   ram_addr;
   logic                   ram_wren;
   logic [2*DATA_BITS-1:0] ram_wdata;

   modport master (output ram_addr, ram_wren, ram_wdata);
   modport slave  (input  ram_addr, ram_wren, ram_wdata);
endinterface

// File: rtl/capture_trigger_ctrl.sv
// Decimating capture sequencer: circular pre-trigger fill, trigger detect, then linear post-trigger fill.
// Defining CAPTURE_TRIG_AVG_EN replaces pick-last-of-window decimation with a window average.
module capture_trigger_ctrl #(
   parameter int ADDR_BITS = 10,
   parameter int DATA_BITS = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [DATA_BITS-1:0] adc0,
   input  logic signed [DATA_BITS-1:0] adc1,
   input  logic                        arm,
   input  logic                        abort,
   input  logic                        sw_trig,
   input  logic [1:0]                  trig_src,
   input  logic                        trig_slope,
   input  logic signed [DATA_BITS-1:0] trig_level,
   input  logic [3:0]                  decim_log2,
   input  logic [ADDR_BITS-1:0]        pre_len,
   capture_trigger_ctrl_if.master      ram,
   output logic                        busy,
   output logic                        waiting,
   output logic                        done,
   output logic [ADDR_BITS-1:0]        trig_addr
);

   localparam logic [ADDR_BITS-1:0] LAST_IDX = {ADDR_BITS{1'b1}};
   localparam logic [ADDR_BITS-1:0] ONE      = {{(ADDR_BITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_WAIT = 2'd2,
      S_POST = 2'd3
   } state_t;

   state_t                      r_state;
   logic [1:0]                  r_src;
   logic                        r_slope;
   logic signed [DATA_BITS-1:0] r_level;
   logic [3:0]                  r_decim;
   logic [ADDR_BITS-1:0]        r_pre;
   logic [ADDR_BITS-1:0]        r_cnt;
   logic                        r_last;
   logic                        r_sw_pend;
   logic [14:0]                 r_dec_cnt;
   logic [ADDR_BITS-1:0]        r_wptr;
   logic signed [DATA_BITS-1:0] r_prev;
   logic                        r_prev_vld;
   logic                        r_wren;
   logic [ADDR_BITS-1:0]        r_addr;
   logic [2*DATA_BITS-1:0]      r_wdata;
   logic                        r_busy;
   logic                        r_waiting;
   logic                        r_done;
   logic [ADDR_BITS-1:0]        r_trig_addr;

   logic [14:0]                 w_term;
   logic                        w_strobe;
   logic                        w_start;
   logic                        w_do_write;
   logic                        w_level_hit;
   logic                        w_fire;
   logic signed [DATA_BITS-1:0] w_dec0;
   logic signed [DATA_BITS-1:0] w_dec1;
   logic signed [DATA_BITS-1:0] w_cur;

   assign w_term     = ~(15'h7FFF << r_decim);
   assign w_strobe   = (r_state != S_IDLE) && (r_dec_cnt == w_term);
   assign w_start    = (r_state == S_IDLE) && arm && !abort;
   // The final POST write is already out when r_last is set; later strobes must not write.
   assign w_do_write = w_strobe && !abort && !((r_state == S_POST) && r_last);
   assign w_cur      = (r_src == 2'd3) ? w_dec1 : w_dec0;

`ifdef CAPTURE_TRIG_AVG_EN
   localparam int ACC_BITS = DATA_BITS + 15;

   logic signed [ACC_BITS-1:0] r_acc0;
   logic signed [ACC_BITS-1:0] r_acc1;
   logic signed [ACC_BITS-1:0] w_sum0;
   logic signed [ACC_BITS-1:0] w_sum1;
   logic signed [ACC_BITS-1:0] w_avg0;
   logic signed [ACC_BITS-1:0] w_avg1;

   assign w_sum0 = (r_dec_cnt == 15'd0) ? ACC_BITS'(adc0) : r_acc0 + ACC_BITS'(adc0);
   assign w_sum1 = (r_dec_cnt == 15'd0) ? ACC_BITS'(adc1) : r_acc1 + ACC_BITS'(adc1);
   assign w_avg0 = w_sum0 >>> r_decim;
   assign w_avg1 = w_sum1 >>> r_decim;
   assign w_dec0 = w_avg0[DATA_BITS-1:0];
   assign w_dec1 = w_avg1[DATA_BITS-1:0];

   // Window accumulators, reloaded by the first sample of each window
   always_ff @(posedge clk) begin
      if (!rst_n || w_start) begin
         r_acc0 <= {ACC_BITS{1'b0}};
         r_acc1 <= {ACC_BITS{1'b0}};
      end else if (r_state != S_IDLE) begin
         r_acc0 <= w_sum0;
         r_acc1 <= w_sum1;
      end
   end
`else
   assign w_dec0 = adc0;
   assign w_dec1 = adc1;
`endif

   // Trigger qualification on the current decimated sample
   always_comb begin
      w_level_hit = 1'b0;
      w_fire      = 1'b0;
      if (r_prev_vld) begin
         if (r_slope) begin
            w_level_hit = (r_prev > r_level) && (w_cur <= r_level);
         end else begin
            w_level_hit = (r_prev < r_level) && (w_cur >= r_level);
         end
      end else begin
         w_level_hit = 1'b0;
      end
      case (r_src)
         2'd0:    w_fire = 1'b1;
         2'd1:    w_fire = r_sw_pend;
         default: w_fire = w_level_hit;
      endcase
   end

   // RAM write port, write pointer, decimation counter and previous-sample history
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wren     <= 1'b0;
         r_addr     <= {ADDR_BITS{1'b0}};
         r_wdata    <= {(2*DATA_BITS){1'b0}};
         r_wptr     <= {ADDR_BITS{1'b0}};
         r_dec_cnt  <= 15'd0;
         r_prev     <= {DATA_BITS{1'b0}};
         r_prev_vld <= 1'b0;
      end else if (w_start) begin
         r_wren     <= 1'b0;
         r_wptr     <= {ADDR_BITS{1'b0}};
         r_dec_cnt  <= 15'd0;
         r_prev_vld <= 1'b0;
      end else begin
         r_wren <= w_do_write;
         if (w_do_write) begin
            r_addr  <= r_wptr;
            r_wdata <= {w_dec1, w_dec0};
            r_wptr  <= r_wptr + ONE;
         end
         if (r_state != S_IDLE) begin
            r_dec_cnt <= w_strobe ? 15'd0 : r_dec_cnt + 15'd1;
         end
         if (w_strobe) begin
            r_prev     <= w_cur;
            r_prev_vld <= 1'b1;
         end
      end
   end

   // Capture sequencer and status flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_src       <= 2'd0;
         r_slope     <= 1'b0;
         r_level     <= {DATA_BITS{1'b0}};
         r_decim     <= 4'd0;
         r_pre       <= {ADDR_BITS{1'b0}};
         r_cnt       <= {ADDR_BITS{1'b0}};
         r_last      <= 1'b0;
         r_sw_pend   <= 1'b0;
         r_busy      <= 1'b0;
         r_waiting   <= 1'b0;
         r_done      <= 1'b0;
         r_trig_addr <= {ADDR_BITS{1'b0}};
      end else if (abort) begin
         r_state   <= S_IDLE;
         r_last    <= 1'b0;
         r_sw_pend <= 1'b0;
         r_busy    <= 1'b0;
         r_waiting <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (arm) begin
                  r_src     <= trig_src;
                  r_slope   <= trig_slope;
                  r_level   <= trig_level;
                  r_decim   <= decim_log2;
                  r_pre     <= pre_len;
                  r_cnt     <= {ADDR_BITS{1'b0}};
                  r_last    <= 1'b0;
                  r_sw_pend <= 1'b0;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  if (pre_len == {ADDR_BITS{1'b0}}) begin
                     r_state   <= S_WAIT;
                     r_waiting <= 1'b1;
                  end else begin
                     r_state <= S_PRE;
                  end
               end
            end
            S_PRE: begin
               if (w_strobe) begin
                  r_cnt <= r_cnt + ONE;
                  if (r_cnt == r_pre - ONE) begin
                     r_state   <= S_WAIT;
                     r_waiting <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (sw_trig) begin
                  r_sw_pend <= 1'b1;
               end
               if (w_strobe && w_fire) begin
                  r_trig_addr <= r_wptr;
                  r_state     <= S_POST;
                  r_waiting   <= 1'b0;
                  r_sw_pend   <= 1'b0;
                  // pre_len is at most 2^ADDR_BITS-1 by width, so the post count never underflows.
                  r_cnt       <= LAST_IDX - r_pre;
                  r_last      <= (r_pre == LAST_IDX);
               end
            end
            S_POST: begin
               if (r_last) begin
                  r_state <= S_IDLE;
                  r_last  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_strobe) begin
                  r_cnt <= r_cnt - ONE;
                  if (r_cnt == ONE) begin
                     r_last <= 1'b1;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_waiting <= 1'b0;
            end
         endcase
      end
   end

   assign ram.ram_addr  = r_addr;
   assign ram.ram_wren  = r_wren;
   assign ram.ram_wdata = r_wdata;
   assign busy          = r_busy;
   assign waiting       = r_waiting;
   assign done          = r_done;
   assign trig_addr     = r_trig_addr;

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Self-checking bench for capture_trigger_ctrl: table of capture scenarios plus abort/reset sequences.
// Expected decimation data follows CAPTURE_TRIG_AVG_EN when the macro is defined.
module tb_capture_trigger_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] adc0 = 16'd0;
   logic [15:0] adc1 = 16'd0;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic        sw_trig = 1'b0;
   logic [1:0]  trig_src = 2'd0;
   logic        trig_slope = 1'b0;
   logic [15:0] trig_level = 16'd0;
   logic [3:0]  decim_log2 = 4'd0;
   logic [9:0]  pre_len = 10'd0;
   logic        busy;
   logic        waiting;
   logic        done;
   logic [9:0]  trig_addr;

   capture_trigger_ctrl_if #(.ADDR_BITS(10), .DATA_BITS(16)) ram_if ();

   capture_trigger_ctrl #(.ADDR_BITS(10), .DATA_BITS(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .adc0       (adc0),
      .adc1       (adc1),
      .arm        (arm),
      .abort      (abort),
      .sw_trig    (sw_trig),
      .trig_src   (trig_src),
      .trig_slope (trig_slope),
      .trig_level (trig_level),
      .decim_log2 (decim_log2),
      .pre_len    (pre_len),
      .ram        (ram_if.master),
      .busy       (busy),
      .waiting    (waiting),
      .done       (done),
      .trig_addr  (trig_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  src;
      logic        slope;
      int          level;
      logic [3:0]  decim;
      int          pre;
      int          start0;
      int          step0;
      int          start1;
      int          step1;
      int          sw_k1;
      int          sw_k2;
      int          exp_taddr;
      logic [31:0] exp_trig_w;
      logic [31:0] exp_old_w;
      int          exp_total;
      int          exp_after;
      int          exp_gap;
      bit          chk_ramp;
   } vec_t;

   localparam int NV = 6;
   vec_t tv [NV];

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          wr_cnt = 0;
   int          last_wr_cyc = -1;
   int          bad_gap = 0;
   int          exp_gap_cur = 1;
   int          after_cnt = -1;
   int          first_wr_addr = -1;
   logic [31:0] trig_w_cur = 32'd0;
   logic [31:0] mem [1024];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic clear_track();
      wr_cnt        = 0;
      last_wr_cyc   = -1;
      bad_gap       = 0;
      after_cnt     = -1;
      first_wr_addr = -1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (ram_if.ram_wren) begin
         if (last_wr_cyc >= 0 && (cyc - last_wr_cyc) != exp_gap_cur) bad_gap++;
         if (wr_cnt == 0) first_wr_addr = int'(ram_if.ram_addr);
         if (after_cnt >= 0) after_cnt++;
         if (after_cnt < 0 && ram_if.ram_wdata == trig_w_cur) after_cnt = 0;
         wr_cnt++;
         last_wr_cyc = cyc;
         mem[ram_if.ram_addr] = ram_if.ram_wdata;
      end
   endtask

   initial begin
      logic [31:0] dec_w;
      int          done_cyc;
      int          bad_ramp;
      int          old_idx;
`ifdef CAPTURE_TRIG_AVG_EN
      dec_w = 32'h0000_0001;
`else
      dec_w = 32'h0000_0003;
`endif
      //        src   slp   lvl   dec  pre   s0     d0 s1   d1  sw1 sw2  taddr  trig_w        old_w         total after gap ramp
      tv[0] = '{2'd0, 1'b0, 0,    4'd0, 0,    0,    1, 0,   0,  -1, -1,  0,    32'h0000_0000, 32'h0000_0000, 1024, 1023, 1, 1'b1};
      tv[1] = '{2'd2, 1'b0, 500,  4'd0, 100,  -1000, 1, 0,  0,  -1, -1,  476,  32'h0000_01F4, 32'h0000_0190, 2424, 923,  1, 1'b0};
      tv[2] = '{2'd0, 1'b0, 0,    4'd2, 0,    0,    1, 0,   0,  -1, -1,  0,    dec_w,         dec_w,         1024, 1023, 4, 1'b0};
      tv[3] = '{2'd1, 1'b0, 0,    4'd0, 10,   0,    1, 0,   0,  3,  30,  31,   32'h0000_001F, 32'h0000_0015, 1045, 1013, 1, 1'b0};
      tv[4] = '{2'd0, 1'b0, 0,    4'd0, 1023, 0,    1, 0,   0,  -1, -1,  1023, 32'h0000_03FF, 32'h0000_0000, 1024, 0,    1, 1'b0};
      tv[5] = '{2'd3, 1'b1, -5,   4'd0, 0,    0,    0, 300, -1, -1, -1,  305,  32'hFFFB_0000, 32'hFFFB_0000, 1329, 1023, 1, 1'b0};

      for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_BEEF;

      rst_n = 1'b0;
      step();
      step();
      check("reset_outputs", 64'({busy, waiting, done, trig_addr, ram_if.ram_wren, ram_if.ram_addr, ram_if.ram_wdata}), 64'd0);
      rst_n = 1'b1;
      step();

      for (int v = 0; v < NV; v++) begin
         trig_src    = tv[v].src;
         trig_slope  = tv[v].slope;
         trig_level  = 16'(tv[v].level);
         decim_log2  = tv[v].decim;
         pre_len     = 10'(tv[v].pre);
         exp_gap_cur = tv[v].exp_gap;
         trig_w_cur  = tv[v].exp_trig_w;
         clear_track();
         done_cyc = -1;
         arm = 1'b1;
         step();
         arm = 1'b0;
         check($sformatf("v%0d_busy_after_arm", v), 64'({busy, done}), 64'b10);
         for (int k = 0; k < 6000 && done_cyc < 0; k++) begin
            adc0    = 16'(tv[v].start0 + tv[v].step0 * k);
            adc1    = 16'(tv[v].start1 + tv[v].step1 * k);
            sw_trig = (k == tv[v].sw_k1) || (k == tv[v].sw_k2);
            step();
            if (done) done_cyc = cyc;
         end
         sw_trig = 1'b0;
         old_idx = (tv[v].exp_taddr - tv[v].pre + 1024) % 1024;
         check($sformatf("v%0d_done_seen", v), 64'(done_cyc >= 0), 64'd1);
         check($sformatf("v%0d_done_timing", v), 64'(done_cyc - last_wr_cyc), 64'd1);
         check($sformatf("v%0d_idle_flags", v), 64'({busy, waiting}), 64'd0);
         check($sformatf("v%0d_trig_addr", v), 64'(trig_addr), 64'(tv[v].exp_taddr));
         check($sformatf("v%0d_total_writes", v), 64'(wr_cnt), 64'(tv[v].exp_total));
         check($sformatf("v%0d_writes_after_trig", v), 64'(after_cnt), 64'(tv[v].exp_after));
         check($sformatf("v%0d_write_spacing", v), 64'(bad_gap), 64'd0);
         check($sformatf("v%0d_trig_word", v), 64'(mem[tv[v].exp_taddr]), 64'(tv[v].exp_trig_w));
         check($sformatf("v%0d_oldest_word", v), 64'(mem[old_idx]), 64'(tv[v].exp_old_w));
         if (tv[v].chk_ramp) begin
            bad_ramp = 0;
            for (int i = 0; i < 1024; i++) begin
               if (mem[i] != {16'd0, 16'(i)}) bad_ramp++;
            end
            check($sformatf("v%0d_ramp_contents", v), 64'(bad_ramp), 64'd0);
         end
         step();
         check($sformatf("v%0d_done_held", v), 64'({done, busy}), 64'b10);
      end

      // Abort in WAIT_TRIG with a simultaneous arm
      trig_src   = 2'd2;
      trig_slope = 1'b0;
      trig_level = 16'd30000;
      pre_len    = 10'd0;
      decim_log2 = 4'd0;
      adc0       = 16'd0;
      adc1       = 16'd0;
      exp_gap_cur = 1;
      arm = 1'b1;
      step();
      arm = 1'b0;
      for (int k = 0; k < 5; k++) step();
      check("abort_pre_waiting", 64'({busy, waiting}), 64'b11);
      clear_track();
      abort = 1'b1;
      arm   = 1'b1;
      step();
      abort = 1'b0;
      arm   = 1'b0;
      check("abort_flags", 64'({busy, waiting, done}), 64'd0);
      check("abort_trig_addr_kept", 64'(trig_addr), 64'(tv[NV-1].exp_taddr));
      for (int k = 0; k < 20; k++) step();
      check("abort_no_writes", 64'(wr_cnt), 64'd0);
      check("abort_arm_ignored", 64'(busy), 64'd0);

      // Re-arm after abort restarts at address 0; then reset mid-POST
      trig_src = 2'd0;
      pre_len  = 10'd5;
      clear_track();
      arm = 1'b1;
      step();
      arm = 1'b0;
      for (int k = 0; k < 40; k++) begin
         adc0 = 16'(k);
         step();
      end
      check("rearm_first_addr", 64'(first_wr_addr), 64'd0);
      check("rearm_in_post", 64'({busy, waiting}), 64'b10);
      check("rearm_trig_addr", 64'(trig_addr), 64'd5);
      rst_n = 1'b0;
      arm   = 1'b1;
      step();
      check("midpost_reset_outputs", 64'({busy, waiting, done, trig_addr, ram_if.ram_wren, ram_if.ram_addr, ram_if.ram_wdata}), 64'd0);
      rst_n = 1'b1;
      arm   = 1'b0;
      step();
      check("reset_arm_ignored", 64'({busy, ram_if.ram_wren}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
